gesture_matcher_multi: RTL and testbench

Parametrised successor to the single-pattern gesture recogniser. It streams N_SAMPLES signed MPU samples per gesture and scores them against N_TEMPLATES stored templates using saturating sum-of-absolute-differences. It then replaces the base letter with the best-matching template's letter when the best score is under THRESHOLD. It sits between the MPU sample front-end and the letter output path of the FPGA glove design.

---
 rtl/gesture_matcher_multi.sv | 181 ++++++++++++++++++
 tb/tb_gesture_matcher_multi.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_matcher_multi.sv
// gesture_matcher_multi
// Streams N_SAMPLES signed samples per gesture, scores the window against
// N_TEMPLATES stored templates with saturating sum-of-absolute-differences,
// and reports the best template's letter when its score is below THRESHOLD,
// otherwise the base letter.
// Optional build macro GESTURE_MATCHER_TIMEOUT_EN: abort a capture after
// TIMEOUT consecutive cycles without an accepted sample.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | template writes allowed, waiting for mov
// CAPTURE | accumulating |sample - template| for every template
// COMPARE | one template per cycle, keeping the strictly lower score
// DONE    | result held until mov drops
module gesture_matcher_multi #(
  parameter int N_SAMPLES   = 30,
  parameter int DATA_W      = 32,
  parameter int N_TEMPLATES = 4,
  parameter int ACC_W       = 40,
  parameter int THRESHOLD   = 3000,
  parameter logic [8*N_TEMPLATES-1:0] LETTERS = {"Z", "S", "J", "H"},
  parameter int TIMEOUT     = 1000,
  localparam int SEL_W = (N_TEMPLATES > 1) ? $clog2(N_TEMPLATES) : 1,
  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mov,
  input  logic signed [DATA_W-1:0] mpu_in,
  input  logic                     mpu_valid,
  input  logic [7:0]               letra_base,
  input  logic                     tpl_we,
  input  logic [SEL_W-1:0]         tpl_sel,
  input  logic [CNT_W-1:0]         tpl_addr,
  input  logic signed [DATA_W-1:0] tpl_data,
  output logic [7:0]               letra_final,
  output logic                     ready,
  output logic                     match,
  output logic [SEL_W-1:0]         match_idx,
  output logic [ACC_W-1:0]         min_sad
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] tpl [N_TEMPLATES][N_SAMPLES];
  logic [ACC_W-1:0]         acc [N_TEMPLATES];
  logic [ACC_W-1:0]         acc_next [N_TEMPLATES];
  logic [CNT_W-1:0]         cnt;
  logic [SEL_W-1:0]         cmp_idx;
  logic [SEL_W-1:0]         best_idx;
  logic [ACC_W-1:0]         best_sad;
  logic [ACC_W-1:0]         cur_sad;
  logic [ACC_W-1:0]         nb_sad;
  logic [SEL_W-1:0]         nb_idx;
  logic                     cmp_last;
  logic                     last_sample;
  logic                     tpl_in_range;

`ifdef GESTURE_MATCHER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  function automatic logic [7:0] letter_of(input logic [SEL_W-1:0] idx);
    logic [8*N_TEMPLATES-1:0] sh;
    sh = LETTERS >> (8 * (N_TEMPLATES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  assign last_sample  = (32'(cnt) == N_SAMPLES - 1);
  assign cmp_last     = (32'(cmp_idx) == N_TEMPLATES - 1);
  assign tpl_in_range = (32'(tpl_sel) < N_TEMPLATES) && (32'(tpl_addr) < N_SAMPLES);

  // Per-template saturating SAD step; the difference needs one extra bit.
  for (genvar t = 0; t < N_TEMPLATES; t++) begin : g_sad
    logic signed [DATA_W:0] diff;
    logic [DATA_W:0]        abs_diff;
    logic [SUM_W-1:0]       sum;
    assign diff     = {mpu_in[DATA_W-1], mpu_in} - {tpl[t][cnt][DATA_W-1], tpl[t][cnt]};
    assign abs_diff = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    assign sum      = {1'b0, acc[t]} + SUM_W'(abs_diff);
    assign acc_next[t] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // Running minimum for the scan; index 0 seeds it, ties keep the earlier index.
  always_comb begin
    cur_sad = acc[cmp_idx];
    nb_sad  = best_sad;
    nb_idx  = best_idx;
    if (cmp_idx == '0 || cur_sad < best_sad) begin
      nb_sad = cur_sad;
      nb_idx = cmp_idx;
    end
  end

  // Sequencer, template storage, accumulators and registered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cmp_idx     <= '0;
      best_idx    <= '0;
      best_sad    <= '0;
      letra_final <= 8'h00;
      ready       <= 1'b0;
      match       <= 1'b0;
      match_idx   <= '0;
      min_sad     <= '0;
      for (int t = 0; t < N_TEMPLATES; t++) begin
        acc[t] <= '0;
        for (int i = 0; i < N_SAMPLES; i++) tpl[t][i] <= '0;
      end
`ifdef GESTURE_MATCHER_TIMEOUT_EN
      tmo_cnt <= TMO_LOAD;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tpl_we && tpl_in_range) tpl[tpl_sel][tpl_addr] <= tpl_data;
          if (mov) begin
            for (int t = 0; t < N_TEMPLATES; t++) acc[t] <= '0;
            cnt   <= '0;
            state <= CAPTURE;
`ifdef GESTURE_MATCHER_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end
        end
        CAPTURE: begin
          if (mpu_valid) begin
            for (int t = 0; t < N_TEMPLATES; t++) acc[t] <= acc_next[t];
            cnt <= cnt + 1'b1;
          end
          // The final sample wins over a simultaneous mov drop.
          if (mpu_valid && last_sample) begin
            state   <= COMPARE;
            cmp_idx <= '0;
          end else if (!mov) begin
            state <= IDLE;
          end
`ifdef GESTURE_MATCHER_TIMEOUT_EN
          else if (mpu_valid) begin
            tmo_cnt <= TMO_LOAD;
          end else if (tmo_cnt == '0) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        COMPARE: begin
          best_sad <= nb_sad;
          best_idx <= nb_idx;
          if (cmp_last) begin
            min_sad     <= nb_sad;
            match_idx   <= nb_idx;
            match       <= (nb_sad < THR);
            letra_final <= (nb_sad < THR) ? letter_of(nb_idx) : letra_base;
            ready       <= 1'b1;
            state       <= DONE;
          end else begin
            cmp_idx <= cmp_idx + 1'b1;
          end
        end
        DONE: begin
          if (!mov) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gesture_matcher_multi.sv
// Self-checking bench for gesture_matcher_multi: directed table, hand-written
// corner sequences and randomized windows against a SAD reference model.
module tb_gesture_matcher_multi;
  localparam int NS = 30;
  localparam int NT = 4;
  localparam longint SAT = (64'sd1 <<< 40) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               mov = 1'b0;
  logic signed [31:0] mpu_in = '0;
  logic               mpu_valid = 1'b0;
  logic [7:0]         letra_base = 8'h44;
  logic               tpl_we = 1'b0;
  logic [1:0]         tpl_sel = '0;
  logic [4:0]         tpl_addr = '0;
  logic signed [31:0] tpl_data = '0;
  logic [7:0]         letra_final;
  logic               ready;
  logic               match;
  logic [1:0]         match_idx;
  logic [39:0]        min_sad;

  int n_checks = 0;
  int n_errors = 0;
  int m_tpl [NT][NS];
  int win [NS];
  int zwin [NS] = '{-865, -854, -685, -720, -802, -910, -1003, -1120, -1204, -1150,
                    -980, -760, -512, -300, -120, 40, 210, 380, 505, 610,
                    580, 430, 220, -15, -230, -410, -560, -640, -600, -550};
  logic [7:0] letters [NT] = '{"Z", "S", "J", "H"};

  typedef struct {
    int         kind;     // 0: Z window + offset, 1: constant offset
    int         offset;
    logic [7:0] base;
    logic [7:0] exp_l;
    bit         exp_m;
    int         exp_idx;
    longint     exp_sad;
  } vec_t;

  vec_t vecs [7] = '{
    '{0,    0, "D", "Z", 1'b1, 0,    0},
    '{0,    1, "D", "Z", 1'b1, 0,   30},
    '{0,   99, "D", "Z", 1'b1, 0, 2970},
    '{0,  100, "D", "D", 1'b0, 0, 3000},
    '{0,  -50, "Q", "Z", 1'b1, 0, 1500},
    '{0, -100, "Q", "Q", 1'b0, 0, 3000},
    '{1, 5000, "D", "S", 1'b1, 1,    0}
  };

  gesture_matcher_multi #(.TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .mov(mov), .mpu_in(mpu_in), .mpu_valid(mpu_valid),
    .letra_base(letra_base), .tpl_we(tpl_we), .tpl_sel(tpl_sel), .tpl_addr(tpl_addr),
    .tpl_data(tpl_data), .letra_final(letra_final), .ready(ready), .match(match),
    .match_idx(match_idx), .min_sad(min_sad)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_tpl(input int sel, input int addr, input int data);
    tpl_we = 1'b1; tpl_sel = 2'(sel); tpl_addr = 5'(addr); tpl_data = data;
    @(negedge clk);
    tpl_we = 1'b0;
    if (addr < NS) m_tpl[sel][addr] = data;
  endtask

  task automatic load_setup(input int t0_is_z, input int rest);
    for (int i = 0; i < NS; i++) write_tpl(0, i, t0_is_z ? zwin[i] : rest);
    for (int t = 1; t < NT; t++)
      for (int i = 0; i < NS; i++) write_tpl(t, i, rest);
  endtask

  // Raise mov, stream win[] with random gaps; returns at the negedge after the last accept.
  task automatic stream(input int gap_max, input bit drop_last, input bit rnd_we);
    mov = 1'b1;
    if (rnd_we) begin
      tpl_we = 1'b1; tpl_sel = 2'($urandom_range(0, 3));
      tpl_addr = 5'($urandom_range(0, NS - 1)); tpl_data = $signed($urandom_range(0, 6000)) - 3000;
      m_tpl[tpl_sel][tpl_addr] = tpl_data;
    end
    @(negedge clk);
    tpl_we = 1'b0;
    for (int i = 0; i < NS; i++) begin
      mpu_valid = 1'b1; mpu_in = win[i];
      if (drop_last && i == NS - 1) mov = 1'b0;
      if (rnd_we) begin
        tpl_we = 1'($urandom_range(0, 1)); tpl_sel = 2'($urandom_range(0, 3));
        tpl_addr = 5'($urandom_range(0, NS - 1)); tpl_data = $signed($urandom);
      end
      @(negedge clk);
      mpu_valid = 1'b0; tpl_we = 1'b0; mpu_in = $signed($urandom);
      if (i < NS - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic wait_ready(input string tag);
    int lat;
    lat = 0;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, NT);
  endtask

  task automatic release_mov(input string tag);
    mov = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_clear"}, ready, 0);
  endtask

  task automatic check_model(input string tag);
    longint s, best;
    int bi;
    bit m;
    logic [7:0] l;
    best = 0; bi = 0;
    for (int t = 0; t < NT; t++) begin
      s = 0;
      for (int i = 0; i < NS; i++) begin
        longint d;
        d = longint'(win[i]) - longint'(m_tpl[t][i]);
        s += (d < 0) ? -d : d;
      end
      if (s > SAT) s = SAT;
      if (t == 0 || s < best) begin best = s; bi = t; end
    end
    m = (best < 3000);
    l = m ? letters[bi] : letra_base;
    chk({tag, "_letra"}, letra_final, l);
    chk({tag, "_match"}, match, m);
    chk({tag, "_idx"}, match_idx, bi);
    chk({tag, "_sad"}, min_sad, best);
  endtask

  initial begin
    int seen;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_letra", letra_final, 0);
    chk("rst_ready", ready, 0);
    chk("rst_match", match, 0);
    chk("rst_idx", match_idx, 0);
    chk("rst_sad", min_sad, 0);
    for (int t = 0; t < NT; t++) for (int i = 0; i < NS; i++) m_tpl[t][i] = 0;
    reset = 1'b1;
    @(negedge clk);

    // Directed table: template 0 = Z window, others 5000
    load_setup(1, 5000);
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NS; i++) win[i] = (vecs[v].kind == 0) ? zwin[i] + vecs[v].offset : vecs[v].offset;
      letra_base = vecs[v].base;
      stream(2, 1'b0, 1'b0);
      wait_ready($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_letra", v), letra_final, vecs[v].exp_l);
      chk($sformatf("vec%0d_match", v), match, vecs[v].exp_m);
      chk($sformatf("vec%0d_idx", v), match_idx, vecs[v].exp_idx);
      chk($sformatf("vec%0d_sad", v), min_sad, vecs[v].exp_sad);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_hold", v), ready, 1);
      release_mov($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_keep", v), letra_final, vecs[v].exp_l);
    end

    // Constant 5000 against templates 1..3 at -5000: no match
    load_setup(1, -5000);
    letra_base = "D";
    for (int i = 0; i < NS; i++) win[i] = 5000;
    stream(1, 1'b0, 1'b0);
    wait_ready("nomatch");
    check_model("nomatch");
    chk("nomatch_big", (min_sad >= 120000) ? 1 : 0, 1);
    release_mov("nomatch");

    // Tie between templates 0 and 1 keeps index 0
    for (int i = 0; i < NS; i++) write_tpl(1, i, zwin[i]);
    for (int i = 0; i < NS; i++) win[i] = zwin[i];
    stream(1, 1'b1, 1'b0);
    wait_ready("tie");
    check_model("tie");

    // Abort after 10 samples, then a full window: accumulators must restart
    mov = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mpu_valid = 1'b1; mpu_in = 32'sd7000;
      @(negedge clk);
    end
    mpu_valid = 1'b0; mov = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (ready) seen = 1; end
    chk("abort_no_ready", seen, 0);
    stream(0, 1'b0, 1'b0);
    wait_ready("restart");
    check_model("restart");
    chk("restart_sad0", min_sad, 0);
    release_mov("restart");

    // Idle gap of 50 cycles inside a capture
    mov = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin mpu_valid = 1'b1; mpu_in = win[i]; @(negedge clk); end
    mpu_valid = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 5; i < NS; i++) begin mpu_valid = 1'b1; mpu_in = win[i]; @(negedge clk); end
    mpu_valid = 1'b0;
    seen = 0;
    repeat (NT + 3) begin @(negedge clk); if (ready) seen = 1; end
`ifdef GESTURE_MATCHER_TIMEOUT_EN
    chk("timeout_ready", seen, 0);
`else
    chk("timeout_ready", seen, 1);
    check_model("notimeout");
`endif
    mov = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of COMPARE
    stream(0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int t = 0; t < NT; t++) for (int i = 0; i < NS; i++) m_tpl[t][i] = 0;
    chk("midrst_letra", letra_final, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_match", match, 0);
    chk("midrst_idx", match_idx, 0);
    chk("midrst_sad", min_sad, 0);
    mov = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    letra_base = "D";
    for (int i = 0; i < NS; i++) win[i] = 0;
    stream(2, 1'b0, 1'b0);
    wait_ready("zero");
    check_model("zero");
    chk("zero_letra_z", letra_final, "Z");
    release_mov("zero");

    // Randomized windows against the reference model
    for (int it = 0; it < 30; it++) begin
      int tt, wide;
      wide = ($urandom_range(0, 7) == 0) ? 1 : 0;
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < NS; i++)
          write_tpl(t, i, wide ? $signed($urandom) : $signed($urandom_range(0, 8000)) - 4000);
      write_tpl($urandom_range(0, 3), 30 + $urandom_range(0, 1), $signed($urandom));
      tt = $urandom_range(0, NT - 1);
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(0, 3))
          0: win[i] = $signed($urandom);
          1: win[i] = m_tpl[tt][i];
          default: win[i] = m_tpl[tt][i] + $signed($urandom_range(0, 300)) - 150;
        endcase
      end
      letra_base = 8'($urandom_range(65, 90));
      stream(3, 1'($urandom_range(0, 1)), 1'b1);
      wait_ready($sformatf("rnd%0d", it));
      check_model($sformatf("rnd%0d", it));
      release_mov($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
